// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle controller: opcodes, state encoding,
// datapath select encodings and the bundled control word.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXEC  = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEXEC = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_AND   = 3'b011,
    ALU_OR    = 3'b100
  } aluop_t;

  typedef enum logic [1:0] {
    SRCB_REGB = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_SIMM = 2'b10,
    SRCB_ZIMM = 2'b11
  } alusrcb_t;

  typedef enum logic [1:0] {
    PC_ALURES = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pcsrc_t;

  typedef struct packed {
    logic     iord;
    logic     ir_write;
    logic     pc_write;
    logic     branch;
    logic     branch_ne;
    logic     mem_read;
    logic     mem_write;
    logic     reg_write;
    logic     reg_dst;
    logic     mem_to_reg;
    logic     alu_src_a;
    alusrcb_t alu_src_b;
    pcsrc_t   pc_src;
    aluop_t   alu_op;
    logic     instr_done;
    logic     illegal_op;
  } ctrl_t;

  // Dispatch from DECODE; the extended opcodes trap when the extension is off.
  function automatic state_t decode_next(input logic [5:0] op, input logic ext);
    state_t nxt;
    case (op)
      OP_LW, OP_SW:    nxt = S_MEMADR;
      OP_RTYPE:        nxt = S_RTEXEC;
      OP_BEQ:          nxt = S_BRANCH;
      OP_J:            nxt = S_JUMP;
      OP_ADDI:         nxt = S_IMMEXEC;
      OP_ANDI, OP_ORI: nxt = ext ? S_IMMEXEC : S_TRAP;
      OP_BNE:          nxt = ext ? S_BRANCH : S_TRAP;
      default:         nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in, control word out.
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       IorD;
  logic       IRWrite;
  logic       PCWrite;
  logic       Branch;
  logic       BranchNe;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemToReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic [2:0] ALUop;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output IorD, IRWrite, PCWrite, Branch, BranchNe, MemRead, MemWrite,
           RegWrite, RegDst, MemToReg, ALUSrcA, ALUSrcB, PCSrc, ALUop,
           instr_done, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  IorD, IRWrite, PCWrite, Branch, BranchNe, MemRead, MemWrite,
           RegWrite, RegDst, MemToReg, ALUSrcA, ALUSrcB, PCSrc, ALUop,
           instr_done, illegal_op, state
  );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Combinational control-word decode from current state; opcode only refines
// IMMEXEC/BRANCH, and i_mem_ready gates the memory-completion strobes.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: o_ctrl.alu_src_b = SRCB_SIMM;
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_SIMM;
      end
      S_MEMRD: begin
        o_ctrl.iord     = 1'b1;
        o_ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.iord       = 1'b1;
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      S_RTEXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_IMMEXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        // Logical immediates are zero-extended; addi keeps the sign-extended path.
        if (i_opcode == OP_ANDI) begin
          o_ctrl.alu_src_b = SRCB_ZIMM;
          o_ctrl.alu_op    = ALU_AND;
        end else if (i_opcode == OP_ORI) begin
          o_ctrl.alu_src_b = SRCB_ZIMM;
          o_ctrl.alu_op    = ALU_OR;
        end else begin
          o_ctrl.alu_src_b = SRCB_SIMM;
        end
      end
      S_IMMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a  = 1'b1;
        o_ctrl.alu_op     = ALU_SUB;
        o_ctrl.pc_src     = PC_ALUOUT;
        o_ctrl.branch     = (i_opcode == OP_BEQ);
        o_ctrl.branch_ne  = (i_opcode == OP_BNE);
        o_ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_src     = PC_JUMP;
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_TRAP:  o_ctrl.illegal_op = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multicycle CPU control FSM: state register and next-state logic here, output
// decode in mc_ctrl_outdec; reset blanks every control while asserted.
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int EXT_ISA  = 1
) (
  input  logic         clk,
  input  logic         reset,
  mc_ctrl_if.master    bus
);

  state_t r_state;
  state_t w_state_next;
  logic   w_ready;
  ctrl_t  w_dec;
  ctrl_t  w_ctrl;

  assign w_ready = (MEM_WAIT != 0) ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = S_FETCH;
    case (r_state)
      S_FETCH:   w_state_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE:  w_state_next = decode_next(bus.opcode, EXT_ISA != 0);
      S_MEMADR:  w_state_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   w_state_next = w_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_state_next = w_ready ? S_FETCH : S_MEMWR;
      S_RTEXEC:  w_state_next = S_ALUWB;
      S_IMMEXEC: w_state_next = S_IMMWB;
      default:   w_state_next = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .i_state     (r_state),
    .i_opcode    (bus.opcode),
    .i_mem_ready (w_ready),
    .o_ctrl      (w_dec)
  );

  assign w_ctrl = reset ? '0 : w_dec;

  assign bus.IorD       = w_ctrl.iord;
  assign bus.IRWrite    = w_ctrl.ir_write;
  assign bus.PCWrite    = w_ctrl.pc_write;
  assign bus.Branch     = w_ctrl.branch;
  assign bus.BranchNe   = w_ctrl.branch_ne;
  assign bus.MemRead    = w_ctrl.mem_read;
  assign bus.MemWrite   = w_ctrl.mem_write;
  assign bus.RegWrite   = w_ctrl.reg_write;
  assign bus.RegDst     = w_ctrl.reg_dst;
  assign bus.MemToReg   = w_ctrl.mem_to_reg;
  assign bus.ALUSrcA    = w_ctrl.alu_src_a;
  assign bus.ALUSrcB    = w_ctrl.alu_src_b;
  assign bus.PCSrc      = w_ctrl.pc_src;
  assign bus.ALUop      = w_ctrl.alu_op;
  assign bus.instr_done = w_ctrl.instr_done;
  assign bus.illegal_op = w_ctrl.illegal_op;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Directed bench: per-cycle expected state/control words queued by the stimulus,
// popped and compared by an independent negedge monitor.
module tb_mc_ctrl_unit;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r_reset  = 1'b1;
  logic       r_ready  = 1'b1;
  logic [5:0] r_opcode = 6'd0;

  mc_ctrl_if bus0();
  mc_ctrl_if busx();

  assign bus0.opcode    = r_opcode;
  assign bus0.mem_ready = r_ready;
  assign busx.opcode    = r_opcode;
  assign busx.mem_ready = r_ready;

  mc_ctrl_unit #(.MEM_WAIT(1), .EXT_ISA(1)) u_dut0 (.clk(clk), .reset(r_reset), .bus(bus0));
  mc_ctrl_unit #(.MEM_WAIT(1), .EXT_ISA(0)) u_dutx (.clk(clk), .reset(r_reset), .bus(busx));

  // Control word layout: IorD..ALUSrcA in [19:9], ALUSrcB [8:7], PCSrc [6:5], ALUop [4:2], done [1], illegal [0]
  localparam logic [19:0] B_IORD = 20'h80000, B_IRW = 20'h40000, B_PCW = 20'h20000;
  localparam logic [19:0] B_BR   = 20'h10000, B_BNE = 20'h08000, B_MRD = 20'h04000;
  localparam logic [19:0] B_MWR  = 20'h02000, B_RW  = 20'h01000, B_RD  = 20'h00800;
  localparam logic [19:0] B_M2R  = 20'h00400, B_ASA = 20'h00200;
  localparam logic [19:0] ASB_FOUR = 20'h00080, ASB_SIMM = 20'h00100, ASB_ZIMM = 20'h00180;
  localparam logic [19:0] PCS_OUT = 20'h00020, PCS_J = 20'h00040;
  localparam logic [19:0] AOP_SUB = 20'h4, AOP_FN = 20'h8, AOP_AND = 20'hC, AOP_OR = 20'h10;
  localparam logic [19:0] B_DONE = 20'h2, B_ILL = 20'h1;

  localparam logic [19:0] E_F_RDY  = B_MRD | B_IRW | B_PCW | ASB_FOUR;
  localparam logic [19:0] E_F_WAIT = B_MRD | ASB_FOUR;
  localparam logic [19:0] E_DEC    = ASB_SIMM;
  localparam logic [19:0] E_MADR   = B_ASA | ASB_SIMM;
  localparam logic [19:0] E_MRD    = B_IORD | B_MRD;
  localparam logic [19:0] E_MWB    = B_M2R | B_RW | B_DONE;
  localparam logic [19:0] E_MWR_W  = B_IORD | B_MWR;
  localparam logic [19:0] E_MWR_R  = B_IORD | B_MWR | B_DONE;
  localparam logic [19:0] E_RTE    = B_ASA | AOP_FN;
  localparam logic [19:0] E_AWB    = B_RD | B_RW | B_DONE;
  localparam logic [19:0] E_ADDI   = B_ASA | ASB_SIMM;
  localparam logic [19:0] E_ANDI   = B_ASA | ASB_ZIMM | AOP_AND;
  localparam logic [19:0] E_ORI    = B_ASA | ASB_ZIMM | AOP_OR;
  localparam logic [19:0] E_IWB    = B_RW | B_DONE;
  localparam logic [19:0] E_BEQ    = B_ASA | AOP_SUB | PCS_OUT | B_BR | B_DONE;
  localparam logic [19:0] E_BNE    = B_ASA | AOP_SUB | PCS_OUT | B_BNE | B_DONE;
  localparam logic [19:0] E_JMP    = PCS_J | B_PCW | B_DONE;
  localparam logic [19:0] E_TRAP   = B_ILL;

  wire [19:0] w_act0 = {bus0.IorD, bus0.IRWrite, bus0.PCWrite, bus0.Branch, bus0.BranchNe,
                        bus0.MemRead, bus0.MemWrite, bus0.RegWrite, bus0.RegDst, bus0.MemToReg,
                        bus0.ALUSrcA, bus0.ALUSrcB, bus0.PCSrc, bus0.ALUop, bus0.instr_done,
                        bus0.illegal_op};
  wire [19:0] w_actx = {busx.IorD, busx.IRWrite, busx.PCWrite, busx.Branch, busx.BranchNe,
                        busx.MemRead, busx.MemWrite, busx.RegWrite, busx.RegDst, busx.MemToReg,
                        busx.ALUSrcA, busx.ALUSrcB, busx.PCSrc, busx.ALUop, busx.instr_done,
                        busx.illegal_op};

  typedef struct {
    string       name;
    logic [3:0]  s0;
    logic [19:0] v0;
    bit          cx;
    logic [3:0]  sx;
    logic [19:0] vx;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string nm, input string what, input logic [19:0] act,
                       input logic [19:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s %s: got %05h required %05h", nm, what, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check(e.name, "dut0.state", {16'd0, bus0.state}, {16'd0, e.s0});
      check(e.name, "dut0.ctrl", w_act0, e.v0);
      if (e.cx) begin
        check(e.name, "dutx.state", {16'd0, busx.state}, {16'd0, e.sx});
        check(e.name, "dutx.ctrl", w_actx, e.vx);
      end
      $display("t=%0t %-12s dut0 state=%0d ctrl=%05h dutx state=%0d ctrl=%05h",
               $time, e.name, bus0.state, w_act0, busx.state, w_actx);
    end
  end

  task automatic cyc2(input string nm, input bit rst, input bit rdy, input logic [5:0] op,
                      input logic [3:0] s0, input logic [19:0] v0, input bit cx,
                      input logic [3:0] sx, input logic [19:0] vx);
    exp_t e;
    @(posedge clk);
    #1;
    r_reset  = rst;
    r_ready  = rdy;
    r_opcode = op;
    e.name = nm; e.s0 = s0; e.v0 = v0; e.cx = cx; e.sx = sx; e.vx = vx;
    sb_q.push_back(e);
  endtask

  task automatic cyc(input string nm, input bit rst, input bit rdy, input logic [5:0] op,
                     input logic [3:0] s, input logic [19:0] v, input bit cx);
    cyc2(nm, rst, rdy, op, s, v, cx, s, v);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // reset: all controls low, state FETCH
    cyc("reset",     1, 1, OP_RTYPE, 4'd0, 20'h0, 1);
    // lw, ready tied high: 5 cycles, both variants identical
    cyc("lw.fetch",  0, 1, OP_LW, 4'd0, E_F_RDY, 1);
    cyc("lw.decode", 0, 1, OP_LW, 4'd1, E_DEC,   1);
    cyc("lw.memadr", 0, 1, OP_LW, 4'd2, E_MADR,  1);
    cyc("lw.memrd",  0, 1, OP_LW, 4'd3, E_MRD,   1);
    cyc("lw.memwb",  0, 1, OP_LW, 4'd4, E_MWB,   1);
    // bne: branch with extension, trap without
    cyc("bne.fetch", 0, 1, OP_BNE, 4'd0, E_F_RDY, 1);
    cyc("bne.decode",0, 1, OP_BNE, 4'd1, E_DEC,   1);
    cyc2("bne.exec", 0, 1, OP_BNE, 4'd8, E_BNE,   1, 4'd12, E_TRAP);
    cyc("bne.next",  0, 1, OP_ADDI, 4'd0, E_F_RDY, 1);
    // addi
    cyc("addi.dec",  0, 1, OP_ADDI, 4'd1, E_DEC,  0);
    cyc("addi.exec", 0, 1, OP_ADDI, 4'd9, E_ADDI, 0);
    cyc("addi.wb",   0, 1, OP_ADDI, 4'd10, E_IWB, 0);
    // sw with three wait cycles in MEMWR
    cyc("sw.fetch",  0, 1, OP_SW, 4'd0, E_F_RDY, 0);
    cyc("sw.decode", 0, 1, OP_SW, 4'd1, E_DEC,   0);
    cyc("sw.memadr", 0, 1, OP_SW, 4'd2, E_MADR,  0);
    for (int i = 0; i < 3; i++) cyc("sw.wait", 0, 0, OP_SW, 4'd5, E_MWR_W, 0);
    cyc("sw.ready",  0, 1, OP_SW, 4'd5, E_MWR_R, 0);
    // ori
    cyc("ori.fetch", 0, 1, OP_ORI, 4'd0, E_F_RDY, 0);
    cyc("ori.dec",   0, 1, OP_ORI, 4'd1, E_DEC,   0);
    cyc("ori.exec",  0, 1, OP_ORI, 4'd9, E_ORI,   0);
    cyc("ori.wb",    0, 1, OP_ORI, 4'd10, E_IWB,  0);
    // andi
    cyc("andi.fetch",0, 1, OP_ANDI, 4'd0, E_F_RDY, 0);
    cyc("andi.dec",  0, 1, OP_ANDI, 4'd1, E_DEC,   0);
    cyc("andi.exec", 0, 1, OP_ANDI, 4'd9, E_ANDI,  0);
    cyc("andi.wb",   0, 1, OP_ANDI, 4'd10, E_IWB,  0);
    // R-type
    cyc("rt.fetch",  0, 1, OP_RTYPE, 4'd0, E_F_RDY, 0);
    cyc("rt.dec",    0, 1, OP_RTYPE, 4'd1, E_DEC,   0);
    cyc("rt.exec",   0, 1, OP_RTYPE, 4'd6, E_RTE,   0);
    cyc("rt.wb",     0, 1, OP_RTYPE, 4'd7, E_AWB,   0);
    // beq
    cyc("beq.fetch", 0, 1, OP_BEQ, 4'd0, E_F_RDY, 0);
    cyc("beq.dec",   0, 1, OP_BEQ, 4'd1, E_DEC,   0);
    cyc("beq.exec",  0, 1, OP_BEQ, 4'd8, E_BEQ,   0);
    // illegal opcode
    cyc("ill.fetch", 0, 1, 6'b111111, 4'd0, E_F_RDY, 0);
    cyc("ill.dec",   0, 1, 6'b111111, 4'd1, E_DEC,   0);
    cyc("ill.trap",  0, 1, 6'b111111, 4'd12, E_TRAP, 0);
    // fetch stalled two cycles, then j
    cyc("j.fwait0",  0, 0, OP_J, 4'd0, E_F_WAIT, 0);
    cyc("j.fwait1",  0, 0, OP_J, 4'd0, E_F_WAIT, 0);
    cyc("j.fetch",   0, 1, OP_J, 4'd0, E_F_RDY,  0);
    cyc("j.dec",     0, 1, OP_J, 4'd1, E_DEC,    0);
    cyc("j.jump",    0, 1, OP_J, 4'd11, E_JMP,   0);
    // reset while lw is waiting in MEMRD
    cyc("rl.fetch",  0, 1, OP_LW, 4'd0, E_F_RDY, 0);
    cyc("rl.dec",    0, 1, OP_LW, 4'd1, E_DEC,   0);
    cyc("rl.memadr", 0, 1, OP_LW, 4'd2, E_MADR,  0);
    cyc("rl.wait",   0, 0, OP_LW, 4'd3, E_MRD,   0);
    cyc("rl.reset",  1, 0, OP_LW, 4'd3, 20'h0,   0);
    cyc("rl.resume", 0, 1, OP_RTYPE, 4'd0, E_F_RDY, 0);
    cyc("rl.dec2",   0, 1, OP_RTYPE, 4'd1, E_DEC,   0);
    cyc("rl.exec",   0, 1, OP_RTYPE, 4'd6, E_RTE,   0);
    cyc("rl.wb",     0, 1, OP_RTYPE, 4'd7, E_AWB,   0);
    cyc("rl.after",  0, 1, OP_RTYPE, 4'd0, E_F_RDY, 0);

    for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending entries required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_unit.md
MC_CTRL_UNIT -- requirements
Module: mc_ctrl_unit

Interface
REQ-001 Parameter MEM_WAIT, default 1: 1 = memory states wait on mem_ready; 0 = mem_ready ignored, treated as 1.
REQ-002 Parameter EXT_ISA, default 1: 1 = andi/ori/bne decoded; 0 = those opcodes are illegal.
REQ-003 clk  input  1  single clock, rising edge; reset is synchronous and active-high.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 opcode  input  6  instruction[31:26], from the instruction register.
REQ-006 mem_ready  input  1  memory access complete this cycle.
REQ-007 IorD, IRWrite, PCWrite, Branch, BranchNe  output  1 each  address select, IR load, unconditional PC load, beq qualifier, bne qualifier.
REQ-008 MemRead, MemWrite, RegWrite, RegDst, MemToReg, ALUSrcA  output  1 each  datapath controls.
REQ-009 ALUSrcB  output  2  00 regB, 01 constant 4, 10 sign-ext imm, 11 zero-ext imm.
REQ-010 PCSrc  output  2  00 ALUResult, 01 ALUOut, 10 jump target.
REQ-011 ALUop  output  3  000 add, 001 sub, 010 use funct, 011 and, 100 or.
REQ-012 instr_done  output  1  one-cycle pulse in the last cycle of each instruction.
REQ-013 illegal_op  output  1  one-cycle pulse in TRAP.
REQ-014 state  output  4  current state encoding, for debug.

Function
REQ-015 Moore FSM: all outputs decode from state only, gated by mem_ready where stated; outputs not listed for a state are 0.
REQ-016 States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, ALUWB 7, BRANCH 8, IMMEXEC 9, IMMWB 10, JUMP 11, TRAP 12; 13-15 go to FETCH next cycle with all outputs 0.
REQ-017 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=000, PCSrc=00; IRWrite=PCWrite=mem_ready; to DECODE when mem_ready, else hold.
REQ-018 DECODE: ALUSrcA=0, ALUSrcB=10, ALUop=000 (branch target); next by opcode: 100011/101011 -> MEMADR, 000000 -> RTEXEC, 000100 -> BRANCH, 000010 -> JUMP, 001000 -> IMMEXEC, 001100/001101/000101 -> IMMEXEC/IMMEXEC/BRANCH if EXT_ISA, all others -> TRAP.
REQ-019 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=000; lw -> MEMRD, sw -> MEMWR.
REQ-020 MEMRD: IorD=1, MemRead=1; to MEMWB when mem_ready, else hold.
REQ-021 MEMWB: RegDst=0, MemToReg=1, RegWrite=1, instr_done=1; -> FETCH.
REQ-022 MEMWR: IorD=1, MemWrite=1; instr_done=mem_ready; to FETCH when mem_ready, else hold.
REQ-023 RTEXEC: ALUSrcA=1, ALUSrcB=00, ALUop=010; -> ALUWB. ALUWB: RegDst=1, MemToReg=0, RegWrite=1, instr_done=1; -> FETCH.
REQ-024 IMMEXEC: ALUSrcA=1; addi ALUSrcB=10/ALUop=000, andi 11/011, ori 11/100; -> IMMWB. IMMWB: RegDst=0, MemToReg=0, RegWrite=1, instr_done=1; -> FETCH.
REQ-025 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=001, PCSrc=01; Branch=1 for 000100, BranchNe=1 for 000101; instr_done=1; -> FETCH.
REQ-026 JUMP: PCSrc=10, PCWrite=1, instr_done=1; -> FETCH.
REQ-027 TRAP: illegal_op=1, no write enable asserted; -> FETCH.
REQ-028 opcode is sampled only in DECODE, MEMADR, IMMEXEC, BRANCH; it is stable there because IRWrite is 0 outside FETCH.
REQ-029 Latency with mem_ready tied 1: lw 5, sw 4, R-type 4, addi/andi/ori 4, beq/bne 3, j 3, illegal 3 cycles; each wait cycle adds 1.

Reset
REQ-030 reset=1 at a rising edge forces state=FETCH regardless of current state, including mid-instruction or mid-wait.
REQ-031 While reset=1, all write enables and strobes (IRWrite, PCWrite, RegWrite, MemRead, MemWrite, Branch, BranchNe, instr_done, illegal_op) are forced 0; selects are 0.

Structure
REQ-032 Package mc_ctrl_pkg holds opcode constants, the state enum, and ALUop, ALUSrcB and PCSrc encodings.
REQ-033 One sub-module, mc_ctrl_outdec: combinational state+opcode+mem_ready -> outputs; the top holds the state register and next-state logic.

Verification
REQ-034 lw (100011), mem_ready=1 -> states 0,1,2,3,4; RegWrite and MemToReg=1 only in cycle 5; instr_done once.
REQ-035 sw, MEM_WAIT=1, mem_ready low for 3 cycles in MEMWR -> MemWrite held 4 cycles; FETCH after the ready cycle; instr_done only with ready.
REQ-036 bne (000101): EXT_ISA=1 -> BRANCH, BranchNe=1, ALUop=001; EXT_ISA=0 -> TRAP, illegal_op pulse, FETCH 3rd cycle.
REQ-037 ori (001101) -> IMMEXEC with ALUSrcB=11, ALUop=100; then IMMWB RegWrite=1, RegDst=0.
REQ-038 reset asserted in MEMRD while waiting -> next state FETCH; all enables 0 during reset; fetch resumes the cycle after release.
REQ-039 FETCH with mem_ready=0 for 2 cycles -> IRWrite/PCWrite 0 until ready; exactly one PC increment.
